// File: rtl/ecc_core_arb_if.sv
// Bus between the ECC engine arbiter, its requesters and the point-arithmetic engine.
// The arbiter sits on the slave side; requesters and the engine drive the master side.
interface ecc_core_arb_if #(
  parameter int NREQ = 2,
  parameter int OPW  = 2
);
  logic                 clr_ecc;
  logic [NREQ-1:0]      req;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err_tmo;
  logic                 busy;
  logic [OPW-1:0]       ecc_op;
  logic                 ecc_en;
  logic                 ecc_clr;
  logic                 ecc_rdy;

  modport master (
    output clr_ecc, req, req_op, ecc_rdy,
    input  gnt, done, err_tmo, busy, ecc_op, ecc_en, ecc_clr
  );

  modport slave (
    input  clr_ecc, req, req_op, ecc_rdy,
    output gnt, done, err_tmo, busy, ecc_op, ecc_en, ecc_clr
  );
endinterface

// File: rtl/ecc_core_arb.sv
// Round-robin arbiter sharing one ECC engine between NREQ requesters, with a
// per-run watchdog and forced engine clear on abort or timeout.
module ecc_core_arb #(
  parameter int               NREQ    = 2,
  parameter int               OPW     = 2,
  parameter int               TMO_W   = 20,
  parameter logic [TMO_W-1:0] TMO_MAX = 20'hFFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  ecc_core_arb_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, START, RUN, FIN, TMO, ABORT} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, owner, pick, nxt_ptr;
  logic [PW:0]      idx_w;
  logic             any_req;
  logic [OPW-1:0]   op_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [NREQ-1:0]  owner_oh;
  logic [OPW-1:0]   ops [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign ops[g] = bus.req_op[g*OPW +: OPW];
  end

  // First pending request at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    idx_w   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(NREQ)) idx_w = idx_w - (PW+1)'(NREQ);
      if (!any_req && bus.req[idx_w[PW-1:0]]) begin
        any_req = 1'b1;
        pick    = idx_w[PW-1:0];
      end
    end
  end

  assign nxt_ptr  = (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);
  assign owner_oh = NREQ'(1) << owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      op_q    <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Only latch a new owner when actually leaving IDLE for START, so an
      // abort arriving in IDLE leaves ecc_op holding the previous opcode.
      if (state == IDLE && !bus.clr_ecc && any_req) begin
        owner <= pick;
        op_q  <= ops[pick];
      end
      if (state == START) tmo_cnt <= '0;
      if (state == RUN && !bus.ecc_rdy && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (state == FIN || state == TMO) rr_ptr <= nxt_ptr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = START;
      START:   state_nxt = RUN;
      RUN: begin
        if (bus.ecc_rdy)            state_nxt = FIN;
        else if (tmo_cnt == TMO_MAX) state_nxt = TMO;
      end
      FIN:     state_nxt = IDLE;
      TMO:     state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.clr_ecc) state_nxt = ABORT;
  end

  always_comb begin
    bus.gnt     = '0;
    bus.done    = '0;
    bus.err_tmo = '0;
    bus.busy    = (state != IDLE);
    bus.ecc_op  = op_q;
    bus.ecc_en  = 1'b0;
    bus.ecc_clr = 1'b0;
    case (state)
      START: begin
        bus.gnt    = owner_oh;
        bus.ecc_en = 1'b1;
      end
      RUN:   bus.gnt = owner_oh;
      FIN: begin
        bus.gnt     = owner_oh;
        bus.done    = owner_oh;
        bus.ecc_clr = 1'b1;
      end
      TMO: begin
        bus.gnt     = owner_oh;
        bus.done    = owner_oh;
        bus.err_tmo = owner_oh;
        bus.ecc_clr = 1'b1;
      end
      ABORT:   bus.ecc_clr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ecc_core_arb.sv
// Scoreboard bench for ecc_core_arb: expected runs are queued when requests are
// driven and checked against each done pulse; a small engine model drives ecc_rdy.
module tb_ecc_core_arb;
  localparam int               NREQ    = 2;
  localparam int               OPW     = 2;
  localparam int               TMO_W   = 20;
  localparam logic [TMO_W-1:0] TMO_MAX = 20'd16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ecc_core_arb_if #(.NREQ(NREQ), .OPW(OPW)) bus ();

  ecc_core_arb #(.NREQ(NREQ), .OPW(OPW), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         owner;
    logic [1:0] op;
    bit         tmo;
    int         len;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   rdy_delay = -1;
  int   exp_ptr   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.gnt, bus.done, bus.err_tmo, bus.busy, bus.ecc_op, bus.ecc_en, bus.ecc_clr});
  endfunction

  function automatic logic [1:0] op_of(input int o);
    return (o == 1) ? 2'b11 : 2'b01;
  endfunction

  function automatic void expect_run(input int o, input logic [1:0] op, input bit tmo, input int len);
    exp_t e;
    e.owner = o; e.op = op; e.tmo = tmo; e.len = len;
    sb.push_back(e);
    exp_ptr = (o + 1) % NREQ;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_en(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.ecc_en) return;
    end
    check_eq("wait_en_timeout", 32'(bus.ecc_en), 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done != '0) return;
    end
    check_eq("wait_done_timeout", 32'(bus.done != '0), 1);
  endtask

  // Engine: raises ecc_rdy for one cycle rdy_delay cycles after ecc_en; never if negative.
  initial begin
    int cnt;
    cnt = -1;
    bus.ecc_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.ecc_clr) begin
        cnt = -1;
        bus.ecc_rdy = 1'b0;
      end else if (bus.ecc_en) begin
        cnt = rdy_delay;
        bus.ecc_rdy = 1'b0;
      end else begin
        bus.ecc_rdy = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.ecc_rdy = 1'b1;
            cnt = -1;
          end
        end
      end
    end
  end

  // Monitor: grant exclusivity every cycle, RUN length and completion vs scoreboard.
  initial begin
    int   run_len;
    exp_t e;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
        if (bus.ecc_en) run_len = 0;
        else if (bus.gnt != '0 && bus.done == '0) run_len++;
        if (bus.done != '0) begin
          if (sb.size() == 0) begin
            check_eq("done_unexpected", 32'(bus.done), 0);
          end else begin
            e = sb.pop_front();
            check_eq("done_owner", 32'(bus.done), 32'(1) << e.owner);
            check_eq("err_tmo", 32'(bus.err_tmo), e.tmo ? (32'(1) << e.owner) : 32'd0);
            check_eq("done_op", 32'(bus.ecc_op), 32'(e.op));
            check_eq("run_len", 32'(run_len), 32'(e.len));
            check_eq("done_clr", 32'(bus.ecc_clr), 1);
            check_eq("done_gnt", 32'(bus.gnt), 32'(bus.done));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got sim time %0t expected completion", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    int o;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_op = '0;
    bus.clr_ecc = 1'b0;
    tick(); tick();
    check_eq("reset_outs", outs(), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", 32'(bus.busy), 0);

    // Single request, opcode changed after grant must not leak through.
    rdy_delay = 5;
    bus.req_op = 4'b0110;
    bus.req = 2'b01;
    expect_run(0, 2'b10, 1'b0, 5);
    tick();
    check_eq("t1_en", 32'(bus.ecc_en), 1);
    check_eq("t1_gnt", 32'(bus.gnt), 2'b01);
    check_eq("t1_op", 32'(bus.ecc_op), 2'b10);
    bus.req_op = 4'b1101;
    for (int c = 2; c <= 7; c++) begin
      tick();
      check_eq("t1_gnt_hold", 32'(bus.gnt), 2'b01);
      check_eq("t1_en_once", 32'(bus.ecc_en), 0);
    end
    check_eq("t1_done", 32'(bus.done), 2'b01);
    bus.req = 2'b00;
    tick();
    check_eq("t1_idle", 32'(bus.busy), 0);
    check_eq("t1_op_hold", 32'(bus.ecc_op), 2'b10);

    // Round robin with both requesters held.
    rdy_delay = 3;
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      o = exp_ptr;
      expect_run(o, op_of(o), 1'b0, 3);
    end
    for (int i = 0; i < 4; i++) wait_done(40);
    bus.req = 2'b00;
    tick();
    check_eq("t2_idle", 32'(bus.busy), 0);

    // Timeout, then the other requester is served.
    rdy_delay = -1;
    bus.req = 2'b11;
    o = exp_ptr;
    expect_run(o, op_of(o), 1'b1, 17);
    wait_done(40);
    check_eq("t3_err_tmo", 32'(bus.err_tmo), 32'(1) << o);
    rdy_delay = 2;
    o = exp_ptr;
    expect_run(o, op_of(o), 1'b0, 2);
    wait_done(20);
    bus.req = 2'b00;
    tick();

    // Ready arrives on the very cycle the watchdog limit is reached.
    rdy_delay = 17;
    bus.req = 2'b01;
    expect_run(0, op_of(0), 1'b0, 17);
    wait_done(40);
    check_eq("t4_no_tmo", 32'(bus.err_tmo), 0);
    bus.req = 2'b00;
    tick();

    // Abort mid-run: no done, and the same requester is re-granted first.
    rdy_delay = -1;
    o = exp_ptr;
    bus.req = 2'(32'(1) << o);
    wait_en(10);
    tick(); tick(); tick();
    bus.clr_ecc = 1'b1;
    tick();
    check_eq("t5_abort_clr", 32'(bus.ecc_clr), 1);
    check_eq("t5_abort_done", 32'(bus.done), 0);
    check_eq("t5_abort_gnt", 32'(bus.gnt), 0);
    check_eq("t5_abort_busy", 32'(bus.busy), 1);
    bus.clr_ecc = 1'b0;
    rdy_delay = 3;
    bus.req = 2'b11;
    expect_run(o, op_of(o), 1'b0, 3);
    expect_run(exp_ptr, op_of(exp_ptr), 1'b0, 3);
    tick();
    check_eq("t5_idle", 32'(bus.busy), 0);
    wait_done(20);
    wait_done(20);
    bus.req = 2'b00;
    tick();

    // Asynchronous reset in RUN, then a fresh grant to requester 1.
    rdy_delay = -1;
    bus.req = 2'b01;
    wait_en(10);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check_eq("t6_async_reset", outs(), 0);
    bus.req = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
    rdy_delay = 3;
    expect_run(1, op_of(1), 1'b0, 3);
    tick();
    check_eq("t6_en", 32'(bus.ecc_en), 1);
    check_eq("t6_gnt", 32'(bus.gnt), 2'b10);
    wait_done(20);
    bus.req = 2'b00;
    tick(); tick();

    check_eq("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
